console_rx_fifo: RTL and testbench



---
 rtl/console_rx_fifo.sv | 105 ++++++++++
 tb/tb_console_rx_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/console_rx_fifo.sv
// Console UART receive FIFO: drains UART bytes into a small buffer popped by the CPU.
// Optional macro CONSOLE_RX_FIFO_OVERFLOW_EN: drain the UART even when full, dropping the byte and flagging overflow.
module console_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           uart_dat_do,
    output logic                  uart_dat_re,
    input  logic                  rd_en,
    output logic [31:0]           rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    // state  | meaning
    // IDLE   | waiting for a valid UART byte; captures it when allowed
    // PULSE  | uart_dat_re high for one cycle to consume the UART byte
    // SETTLE | dead cycle while the UART updates its data register
    typedef enum logic [1:0] {IDLE, PULSE, SETTLE} state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  byte_valid;
    logic                  push;
    logic                  pop;
    logic                  take;
    logic                  unused_dat;

    assign unused_dat = ^uart_dat_do[30:8];
    assign byte_valid = ~uart_dat_do[31];
    assign empty      = (count == '0);
    assign full       = (count == DEPTH_CNT);
    // full is the pre-pop value, so a pop in the same cycle never frees room for the push
    assign push       = (state == IDLE) && byte_valid && !full;
    assign pop        = rd_en && !empty;
    assign rd_data    = empty ? 32'h0 : {24'h0, mem[rd_ptr]};

`ifdef CONSOLE_RX_FIFO_OVERFLOW_EN
    logic overflow_q;

    assign take     = (state == IDLE) && byte_valid;
    assign overflow = overflow_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow_q <= 1'b0;
        end else if ((state == IDLE) && byte_valid && full) begin
            overflow_q <= 1'b1;
        end
    end
`else
    assign take     = push;
    assign overflow = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= uart_dat_do[7:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            uart_dat_re <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            uart_dat_re <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state       <= PULSE;
                        uart_dat_re <= 1'b1;
                    end
                end
                PULSE:   state <= SETTLE;
                SETTLE:  state <= IDLE;
                default: state <= IDLE;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_console_rx_fifo.sv
// Directed bench for console_rx_fifo with a simple UART byte-source model.
module tb_console_rx_fifo;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] uart_dat_do;
    logic        uart_dat_re;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;

    logic [7:0] src [0:31];
    int src_head  = 0;
    int src_tail  = 0;
    int pulse_cnt = 0;
    int vectors     = 0;
    int miscompares = 0;

    console_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .CLK(CLK), .RST(RST),
        .uart_dat_do(uart_dat_do), .uart_dat_re(uart_dat_re),
        .rd_en(rd_en), .rd_data(rd_data),
        .count(count), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    assign uart_dat_do = (src_head < src_tail) ? {24'h0, src[src_head]} : 32'hFFFF_FFFF;

    // UART model: a pulse seen at a clock edge consumes the current byte
    always @(posedge CLK) begin
        if (uart_dat_re) begin
            pulse_cnt = pulse_cnt + 1;
            src_head  = src_head + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        rd_en = 1'b0;
        src_head = 0;
        src_tail = 0;
        tick();
        tick();
        RST = 1'b0;
        pulse_cnt = 0;
    endtask

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            src[src_tail] = first + 8'(i);
            src_tail = src_tail + 1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        vectors++; if (uart_dat_re !== 1'b0) begin miscompares++; $display("FAIL reset_re got %0b want 0", uart_dat_re); end
        vectors++; if (pulse_cnt !== 0) begin miscompares++; $display("FAIL reset_pulses got %0d want 0", pulse_cnt); end
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %0b want 1", empty); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %0b want 0", full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_single();
        do_reset();
        load(8'h41, 1);
        tick();
        vectors++; if (rd_data !== 32'h41) begin miscompares++; $display("FAIL single_latency got %h want 41", rd_data); end
        vectors++; if (uart_dat_re !== 1'b1) begin miscompares++; $display("FAIL single_re got %0b want 1", uart_dat_re); end
        for (int i = 0; i < 6; i++) tick();
        vectors++; if (pulse_cnt !== 1) begin miscompares++; $display("FAIL single_pulses got %0d want 1", pulse_cnt); end
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", count); end
        vectors++; if (rd_data !== 32'h41) begin miscompares++; $display("FAIL single_rd_data got %h want 41", rd_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL single_pop_data got %h want 0", rd_data); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL single_pop_empty got %0b want 1", empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL empty_pop_count got %0d want 0", count); end
    endtask

    task automatic test_fill();
        do_reset();
        load(8'h30, 17);
        for (int i = 0; i < 70; i++) tick();
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL fill_count got %0d want 16", count); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %0b want 1", full); end
`ifdef CONSOLE_RX_FIFO_OVERFLOW_EN
        vectors++; if (pulse_cnt !== 17) begin miscompares++; $display("FAIL fill_pulses got %0d want 17", pulse_cnt); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fill_overflow got %0b want 1", overflow); end
`else
        vectors++; if (pulse_cnt !== 16) begin miscompares++; $display("FAIL fill_pulses got %0d want 16", pulse_cnt); end
        vectors++; if (uart_dat_do !== 32'h40) begin miscompares++; $display("FAIL fill_held got %h want 40", uart_dat_do); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fill_overflow got %0b want 0", overflow); end
`endif
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (rd_data !== 32'h30 + 32'(i)) begin
                miscompares++;
                $display("FAIL fill_order[%0d] got %h want %h", i, rd_data, 32'h30 + 32'(i));
            end
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
`ifdef CONSOLE_RX_FIFO_OVERFLOW_EN
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL fill_tail got %h want 0", rd_data); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fill_tail_empty got %0b want 1", empty); end
`else
        vectors++; if (rd_data !== 32'h40) begin miscompares++; $display("FAIL fill_tail got %h want 40", rd_data); end
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL fill_tail_count got %0d want 1", count); end
        vectors++; if (pulse_cnt !== 17) begin miscompares++; $display("FAIL fill_tail_pulses got %0d want 17", pulse_cnt); end
`endif
    endtask

    task automatic test_pop_push_full();
        do_reset();
        load(8'h50, 16);
        for (int i = 0; i < 60; i++) tick();
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL ppf_prefill got %0d want 16", count); end
        load(8'h60, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++; if (count !== 5'd15) begin miscompares++; $display("FAIL ppf_count got %0d want 15", count); end
        vectors++; if (rd_data !== 32'h51) begin miscompares++; $display("FAIL ppf_head got %h want 51", rd_data); end
`ifdef CONSOLE_RX_FIFO_OVERFLOW_EN
        vectors++; if (uart_dat_re !== 1'b1) begin miscompares++; $display("FAIL ppf_re got %0b want 1", uart_dat_re); end
        tick();
        vectors++; if (count !== 5'd15) begin miscompares++; $display("FAIL ppf_drop got %0d want 15", count); end
`else
        vectors++; if (uart_dat_re !== 1'b0) begin miscompares++; $display("FAIL ppf_re got %0b want 0", uart_dat_re); end
        tick();
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL ppf_capture got %0d want 16", count); end
        vectors++; if (uart_dat_re !== 1'b1) begin miscompares++; $display("FAIL ppf_capture_re got %0b want 1", uart_dat_re); end
`endif
        rd_en = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        rd_en = 1'b0;
`ifdef CONSOLE_RX_FIFO_OVERFLOW_EN
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL ppf_last got %h want 0", rd_data); end
`else
        vectors++; if (rd_data !== 32'h60) begin miscompares++; $display("FAIL ppf_last got %h want 60", rd_data); end
`endif
    endtask

    task automatic test_reset_in_pulse();
        bit hit = 1'b0;
        do_reset();
        load(8'h70, 3);
        for (int i = 0; i < 30 && !hit; i++) begin
            tick();
            if (count === 5'd3 && uart_dat_re === 1'b1) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL rip_reach got count=%0d re=%0b want count=3 re=1", count, uart_dat_re);
        end
        #2;
        RST = 1'b1;
        #1;
        vectors++; if (uart_dat_re !== 1'b0) begin miscompares++; $display("FAIL rip_re got %0b want 0", uart_dat_re); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL rip_count got %0d want 0", count); end
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL rip_rd_data got %h want 0", rd_data); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rip_overflow got %0b want 0", overflow); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_pop_push_full();
        test_reset_in_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
